fifo_16i_32o_sync: RTL and testbench
====================================

FIFO_16I_32O_SYNC -- requirements
Module: fifo_16i_32o_sync

Interface
REQ-001 The block SHALL have parameter WR_DEPTH_WIDTH, default 11, meaning log2 of capacity in 16-bit write words (2048).
REQ-002 The block SHALL have parameter ALMOST_FULL_NUM, default 2040, which is the wr_water_level threshold for almost_full.
REQ-003 The block SHALL have parameter ALMOST_EMPTY_NUM, default 4, which is the rd_water_level threshold for almost_empty.
REQ-004 clk  in  1  single clock; all logic is clocked on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_data  in  16  write data word.
REQ-007 wr_en  in  1  write request.
REQ-008 wr_full  out  1  asserted when no 16-bit location is free.
REQ-009 wr_water_level  out  WR_DEPTH_WIDTH+1  number of stored 16-bit words.
REQ-010 almost_full  out  1  asserted when wr_water_level >= ALMOST_FULL_NUM.
REQ-011 rd_data  out  32  read data word.
REQ-012 rd_en  in  1  read request.
REQ-013 rd_empty  out  1  asserted when fewer than two 16-bit words are stored.
REQ-014 rd_water_level  out  WR_DEPTH_WIDTH  number of complete 32-bit words stored, equal to floor(wr_water_level/2).
REQ-015 almost_empty  out  1  asserted when rd_water_level <= ALMOST_EMPTY_NUM.

Function
REQ-016 A write SHALL be accepted when wr_en=1 and wr_full=0; a write while full SHALL be ignored, with no pointer, count or data change.
REQ-017 A read SHALL be accepted when rd_en=1 and rd_empty=0; a read while empty SHALL be ignored, and rd_data SHALL hold its value.
REQ-018 Packing order: the older 16-bit word of each pair SHALL appear on rd_data[15:0] and the newer on rd_data[31:16].
REQ-019 Write pointer: WR_DEPTH_WIDTH+1 bits, +1 per accepted write. Read pointer: WR_DEPTH_WIDTH bits, +1 per accepted read, addressing pairs. Both pointers SHALL wrap naturally modulo their width.
REQ-020 Count update per cycle: +1 per accepted write, -2 per accepted read. Simultaneous accepted write and read SHALL net -1.
REQ-021 All flags and levels SHALL be derived from the registered count, so they reflect accepted operations starting the cycle after the clock edge.
REQ-022 wr_full SHALL assert exactly when the count equals 2**WR_DEPTH_WIDTH.
REQ-023 A pending odd word (count=1) SHALL keep rd_empty=1 until its partner is written; the partner write and a read in the same cycle SHALL not be accepted as a read that cycle.
REQ-024 Read latency: rd_data SHALL present the accepted pair one cycle after the accepting edge and hold until the next accepted read.
REQ-025 Storage SHALL be one 2**WR_DEPTH_WIDTH x 16 memory (or two interleaved halves) inferable as block RAM; no data loss SHALL occur when reading at full.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL clear pointers and count to 0 and set the outputs to rd_data=0, wr_full=0, rd_empty=1, almost_empty=1, almost_full=0, and both water levels=0.
REQ-027 Reset mid-operation SHALL discard all stored data, including a pending odd word; wr_en and rd_en SHALL be ignored during the reset cycle; memory contents need not be cleared.

Configuration
REQ-028 Macro FIFO_16I_32O_OUTPUT_REG_EN defined: an extra rd_data register stage SHALL be added, giving read latency 2 cycles; reset clears both stages.
REQ-029 Macro FIFO_16I_32O_OUTPUT_REG_EN undefined: read latency SHALL be 1 cycle per REQ-024; flag and level timing SHALL be identical in both builds.

Verification
REQ-030 Reset, then write 0x1111 and 0x2222, then pulse rd_en -> rd_data=0x2222_1111 one cycle later (two cycles with the macro); rd_empty=1 afterwards.
REQ-031 Write 2048 words counting down from 0xFFFF -> wr_full=1 and wr_water_level=2048 after the last write; the 2049th write is ignored; almost_full asserts at level 2040.
REQ-032 Read all 1024 pairs back-to-back -> each rd_data equals {cnt-1, cnt}, decrementing; rd_empty asserts after the 1024th read; almost_empty is set at rd_water_level 4.
REQ-033 With the FIFO full, perform simultaneous write and read -> the read is accepted, the write is ignored, and the level drops to 2046; at level 3, simultaneous write and read -> level becomes 2.
REQ-034 Write a single word, then hold rd_en=1 -> rd_empty stays 1 and rd_data is unchanged; a second write asserts rd_water_level=1 and the next read returns the pair.
REQ-035 Write 10 words, then assert rst for one cycle -> all levels=0 and rd_empty=1; 3000 wrap-around writes/reads after reset keep data intact.

Source files
------------

// File: rtl/fifo_16i_32o_sync.sv
// fifo_16i_32o_sync: single-clock FIFO, 16-bit write side and 32-bit read side.
// Two 16-bit writes form one 32-bit read word. The older word lands in
// rd_data[15:0] and the newer word in rd_data[31:16].
// Storage is split into two interleaved banks, even and odd write
// addresses, so one read address fetches a whole pair in one cycle.
// Optional macro FIFO_16I_32O_OUTPUT_REG_EN adds a second rd_data register.
// With the macro, read latency is 2 cycles. Flag timing is the same either way.
module fifo_16i_32o_sync #(
  parameter int WR_DEPTH_WIDTH   = 11,
  parameter int ALMOST_FULL_NUM  = 2040,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  output logic [31:0]               rd_data,
  input  logic                      rd_en,
  output logic                      rd_empty,
  output logic [WR_DEPTH_WIDTH-1:0] rd_water_level,
  output logic                      almost_empty
);

  localparam int AW = WR_DEPTH_WIDTH;
  localparam int BANK_DEPTH = 2 ** (AW - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(2 ** AW);
  localparam logic [AW:0]   AF_LVL   = (AW + 1)'(ALMOST_FULL_NUM);
  localparam logic [AW-1:0] AE_LVL   = AW'(ALMOST_EMPTY_NUM);
  localparam logic [AW:0]   ONE      = (AW + 1)'(1);
  localparam logic [AW:0]   TWO      = (AW + 1)'(2);

  // Write pointer counts 16-bit words. Bit 0 selects the bank.
  // Bits [AW-1:1] give the address inside the bank.
  // Bit AW is the lap bit. Occupancy comes from cnt, so the lap bit is
  // only carried along.
  logic [AW:0]   wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic          wr_acc;
  logic          rd_acc;
  logic          wr_lap_unused;

  logic [15:0] mem_lo [BANK_DEPTH];
  logic [15:0] mem_hi [BANK_DEPTH];
  logic [31:0] rd_q;

  // Flags and levels are decoded from the registered count only.
  assign wr_full        = (cnt == FULL_CNT);
  assign rd_empty       = (cnt[AW:1] == '0);
  assign wr_water_level = cnt;
  assign rd_water_level = cnt[AW:1];
  assign almost_full    = (cnt >= AF_LVL);
  assign almost_empty   = (cnt[AW:1] <= AE_LVL);
  assign wr_lap_unused  = wr_ptr[AW];

  // The accept terms use the registered flags. A lone odd word therefore
  // cannot be read in the same cycle its partner is written.
  assign wr_acc = wr_en & ~wr_full;
  assign rd_acc = rd_en & ~rd_empty;

  // Next occupancy: a write adds one word, a read removes two.
  always_comb begin
    cnt_nxt = cnt;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = cnt + ONE;
      2'b01:   cnt_nxt = cnt - TWO;
      2'b11:   cnt_nxt = cnt - ONE;
      default: cnt_nxt = cnt;
    endcase
  end

  // Update the pointers and the count. Reset drops everything stored,
  // including a half-filled pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt_nxt;
    end
  end

  // Bank write with no reset, so the banks can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      if (wr_ptr[0]) mem_hi[wr_ptr[AW-1:1]] <= wr_data;
      else           mem_lo[wr_ptr[AW-1:1]] <= wr_data;
    end
  end

  // Registered pair read. It loads only on an accepted read, so the data
  // holds between reads.
  always_ff @(posedge clk) begin
    if (rst)         rd_q <= '0;
    else if (rd_acc) rd_q <= {mem_hi[rd_ptr[AW-2:0]], mem_lo[rd_ptr[AW-2:0]]};
  end

`ifdef FIFO_16I_32O_OUTPUT_REG_EN
  logic [31:0] rd_q2;

  // Extra output stage. It follows the first stage one cycle later.
  always_ff @(posedge clk) begin
    if (rst) rd_q2 <= '0;
    else     rd_q2 <= rd_q;
  end

  assign rd_data = rd_q2;
`else
  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_fifo_16i_32o_sync.sv
// Bench for fifo_16i_32o_sync. The reference is a queue of 16-bit words.
// The expected rd_data is taken from the two oldest queued words.
module tb_fifo_16i_32o_sync;

  localparam int W = 11;
  localparam int CAP = 2 ** W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          wr_en = 1'b0;
  logic          wr_full;
  logic [W:0]    wr_water_level;
  logic          almost_full;
  logic [31:0]   rd_data;
  logic          rd_en = 1'b0;
  logic          rd_empty;
  logic [W-1:0]  rd_water_level;
  logic          almost_empty;

  int passed = 0;
  int total  = 0;

  logic [15:0] q[$];
  logic [31:0] st1 = '0;
  logic [31:0] st2 = '0;

  fifo_16i_32o_sync #(.WR_DEPTH_WIDTH(W), .ALMOST_FULL_NUM(2040), .ALMOST_EMPTY_NUM(4)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
    .wr_water_level(wr_water_level), .almost_full(almost_full), .rd_data(rd_data),
    .rd_en(rd_en), .rd_empty(rd_empty), .rd_water_level(rd_water_level),
    .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_out();
`ifdef FIFO_16I_32O_OUTPUT_REG_EN
    return st2;
`else
    return st1;
`endif
  endfunction

  // Runs one clock cycle, advances the model, then checks every output.
  task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic rs);
    int n;
    bit wa, ra;
    wr_en = w; wr_data = d; rd_en = r; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete(); st1 = '0; st2 = '0;
    end else begin
      n  = q.size();
      wa = w && (n < CAP);
      ra = r && (n >= 2);
      st2 = st1;
      if (ra) begin
        st1 = {q[1], q[0]};
        void'(q.pop_front());
        void'(q.pop_front());
      end
      if (wa) q.push_back(d);
    end
    #1;
    n = q.size();
    chk("wr_water_level", 32'(wr_water_level), 32'(n));
    chk("rd_water_level", 32'(rd_water_level), 32'(n / 2));
    chk("wr_full",        32'(wr_full),        32'(n == CAP));
    chk("rd_empty",       32'(rd_empty),       32'(n < 2));
    chk("almost_full",    32'(almost_full),    32'(n >= 2040));
    chk("almost_empty",   32'(almost_empty),   32'((n / 2) <= 4));
    chk("rd_data",        rd_data,             exp_out());
  endtask

  initial begin
    // Reset values.
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_empty", 32'(rd_empty), 32'd1);

    // Basic pair packing and read latency.
    cyc(1'b1, 16'h1111, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
`ifdef FIFO_16I_32O_OUTPUT_REG_EN
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
`endif
    chk("pair_0x22221111", rd_data, 32'h2222_1111);
    chk("pair_empty_after", 32'(rd_empty), 32'd1);

    // Fill to capacity counting down, then try one extra write.
    for (int i = 0; i < CAP; i++) cyc(1'b1, 16'(16'hFFFF - i), 1'b0, 1'b0);
    chk("full_level", 32'(wr_water_level), 32'd2048);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("full_ignored", 32'(wr_water_level), 32'd2048);

    // Read every pair back to back; the model checks each {cnt-1,cnt}.
    for (int i = 0; i < CAP / 2; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("drained_empty", 32'(rd_empty), 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);

    // Simultaneous write and read at full, then at level 3.
    for (int i = 0; i < CAP; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("full_wr_rd_level", 32'(wr_water_level), 32'd2046);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0A00 + i), 1'b0, 1'b0);
    cyc(1'b1, 16'h0A03, 1'b1, 1'b0);
    chk("lvl3_wr_rd_level", 32'(wr_water_level), 32'd2);

    // A pending odd word blocks reads until its partner arrives.
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    cyc(1'b1, 16'h5A5A, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b1, 16'hA5A5, 1'b1, 1'b0);
    chk("odd_partner_level", 32'(rd_water_level), 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
`ifdef FIFO_16I_32O_OUTPUT_REG_EN
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
`endif
    chk("odd_pair_data", rd_data, 32'hA5A5_5A5A);

    // Reset mid-stream with requests active, then a long random run that
    // wraps both pointers.
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 16'h7777, 1'b1, 1'b1);
    chk("midreset_level", 32'(wr_water_level), 32'd0);
    chk("midreset_empty", 32'(rd_empty), 32'd1);
    for (int i = 0; i < 6000; i++) begin
      int pw, pr;
      pw = (i < 2000) ? 80 : (i < 4000) ? 45 : 60;
      pr = (i < 2000) ? 30 : (i < 4000) ? 55 : 30;
      cyc(1'($urandom_range(0, 99) < pw), 16'($urandom), 1'($urandom_range(0, 99) < pr), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
